// File: rtl/exc_intr_ctrl_if.sv
// rtl/exc_intr_ctrl_if.sv - pipeline/CP0 signal bundle for the exception and interrupt controller
interface exc_intr_ctrl_if;
    logic        intr;
    logic        exc_sys;
    logic        exc_uni;
    logic        exc_ovf;
    logic [31:0] exc_pc;
    logic [31:0] next_pc;
    logic        eret;
    logic        c0_we;
    logic [4:0]  c0_addr;
    logic [31:0] c0_wdata;
    logic [31:0] c0_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;

    modport master (
        output intr, exc_sys, exc_uni, exc_ovf, exc_pc, next_pc, eret,
               c0_we, c0_addr, c0_wdata,
        input  c0_rdata, redirect, redirect_pc, flush
    );

    modport slave (
        input  intr, exc_sys, exc_uni, exc_ovf, exc_pc, next_pc, eret,
               c0_we, c0_addr, c0_wdata,
        output c0_rdata, redirect, redirect_pc, flush
    );
endinterface

// File: rtl/exc_intr_ctrl.sv
// rtl/exc_intr_ctrl.sv - CP0 Status/Cause/EPC with exception/interrupt entry and eret return sequencing
module exc_intr_ctrl (
    input  logic           clk,
    input  logic           rst,
    exc_intr_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ENTER, HANDLER, RETURN} state_e;

    localparam logic [4:0]  ADDR_STATUS = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE  = 5'd13;
    localparam logic [4:0]  ADDR_EPC    = 5'd14;
    localparam logic [31:0] VECTOR_PC   = 32'h0000_0008;

    state_e      state_q, state_d;
    logic [4:0]  status_q, status_d;
    logic [1:0]  exccode_q, exccode_d;
    logic        ip_q, ip_d;
    logic [31:0] epc_q, epc_d;
    logic        intr_prev_q, intr_prev_d;

    logic        active;
    logic        intr_edge;
    logic        accept;
    logic [1:0]  accept_code;
    logic [31:0] cause;

    // ENTER and RETURN are bubbles: nothing from the pipeline is honoured there
    assign active    = (state_q == IDLE) || (state_q == HANDLER);
    assign intr_edge = bus.intr & ~intr_prev_q & active;
    assign cause     = {23'd0, ip_q, 4'd0, exccode_q, 2'd0};

    always_comb begin
        accept      = 1'b0;
        accept_code = 2'd0;
        if (state_q == IDLE && !status_q[4]) begin
            if (bus.exc_ovf && status_q[3]) begin
                accept      = 1'b1;
                accept_code = 2'd3;
            end else if (bus.exc_uni && status_q[2]) begin
                accept      = 1'b1;
                accept_code = 2'd2;
            end else if (bus.exc_sys && status_q[1]) begin
                accept      = 1'b1;
                accept_code = 2'd1;
            end else if (ip_q && status_q[0]) begin
                accept      = 1'b1;
                accept_code = 2'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)   state_d = ENTER;
            ENTER:                 state_d = HANDLER;
            HANDLER: if (bus.eret) state_d = RETURN;
            RETURN:                state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.redirect    = 1'b0;
        bus.flush       = 1'b0;
        bus.redirect_pc = 32'd0;
        case (state_q)
            ENTER: begin
                bus.redirect    = 1'b1;
                bus.flush       = 1'b1;
                bus.redirect_pc = VECTOR_PC;
            end
            RETURN: begin
                bus.redirect    = 1'b1;
                bus.flush       = 1'b1;
                bus.redirect_pc = epc_q;
            end
            default: ;
        endcase
    end

    // Acceptance and eret are applied after mtc0 so they own EXL/EPC on a collision
    always_comb begin
        status_d    = status_q;
        exccode_d   = exccode_q;
        ip_d        = ip_q | intr_edge;
        epc_d       = epc_q;
        intr_prev_d = bus.intr;
        if (active && bus.c0_we) begin
            if (bus.c0_addr == ADDR_STATUS) status_d = bus.c0_wdata[4:0];
            if (bus.c0_addr == ADDR_EPC)    epc_d    = bus.c0_wdata;
        end
        if (accept) begin
            exccode_d   = accept_code;
            status_d[4] = 1'b1;
            if (accept_code == 2'd0) begin
                epc_d = bus.next_pc;
                ip_d  = intr_edge;
            end else begin
                epc_d = bus.exc_pc;
            end
        end
        if (state_q == HANDLER && bus.eret) status_d[4] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q    <= 5'd0;
            exccode_q   <= 2'd0;
            ip_q        <= 1'b0;
            epc_q       <= 32'd0;
            intr_prev_q <= 1'b0;
        end else begin
            status_q    <= status_d;
            exccode_q   <= exccode_d;
            ip_q        <= ip_d;
            epc_q       <= epc_d;
            intr_prev_q <= intr_prev_d;
        end
    end

    always_comb begin
        case (bus.c0_addr)
            ADDR_STATUS: bus.c0_rdata = {27'd0, status_q};
            ADDR_CAUSE:  bus.c0_rdata = cause;
            ADDR_EPC:    bus.c0_rdata = epc_q;
            default:     bus.c0_rdata = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_exc_intr_ctrl.sv
// tb/tb_exc_intr_ctrl.sv - directed self-checking bench for exc_intr_ctrl
module tb_exc_intr_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    exc_intr_ctrl_if bus ();

    exc_intr_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] e);
        bus.c0_addr = a;
        #1;
        check(tag, bus.c0_rdata, e);
    endtask

    task automatic chk_out(input string tag, input logic r, input logic [31:0] pc);
        check({tag, ".redirect"}, {31'd0, bus.redirect}, {31'd0, r});
        check({tag, ".flush"}, {31'd0, bus.flush}, {31'd0, r});
        check({tag, ".pc"}, bus.redirect_pc, pc);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.c0_we    = 1'b1;
        bus.c0_addr  = a;
        bus.c0_wdata = d;
        tick();
        bus.c0_we    = 1'b0;
    endtask

    initial begin
        bus.intr = 0; bus.exc_sys = 0; bus.exc_uni = 0; bus.exc_ovf = 0;
        bus.exc_pc = 0; bus.next_pc = 0; bus.eret = 0;
        bus.c0_we = 0; bus.c0_addr = 0; bus.c0_wdata = 0;
        tick(); tick();
        chk_out("rst", 1'b0, 32'h0);
        rd("rst.status", 5'd12, 32'h0);
        rd("rst.cause", 5'd13, 32'h0);
        rd("rst.epc", 5'd14, 32'h0);
        rst = 1'b0;
        tick();
        // all sources masked after reset
        bus.exc_ovf = 1; bus.exc_pc = 32'h44;
        tick();
        bus.exc_ovf = 0;
        chk_out("masked_rst", 1'b0, 32'h0);

        // overflow entry and return
        wr(5'd12, 32'h0F);
        rd("wr.status", 5'd12, 32'h0F);
        bus.exc_ovf = 1; bus.exc_pc = 32'h84;
        tick();
        bus.exc_ovf = 0;
        chk_out("ovf.enter", 1'b1, 32'h08);
        rd("ovf.cause", 5'd13, 32'h0C);
        rd("ovf.epc", 5'd14, 32'h84);
        rd("ovf.status", 5'd12, 32'h1F);
        tick();
        chk_out("ovf.handler", 1'b0, 32'h0);
        bus.eret = 1;
        tick();
        bus.eret = 0;
        chk_out("ovf.return", 1'b1, 32'h84);
        tick();
        chk_out("ovf.idle", 1'b0, 32'h0);

        // uni beats sys; mtc0 during ENTER ignored
        bus.exc_sys = 1; bus.exc_uni = 1; bus.exc_pc = 32'h8C;
        tick();
        bus.exc_sys = 0; bus.exc_uni = 0;
        rd("pri.cause", 5'd13, 32'h08);
        bus.c0_we = 1; bus.c0_addr = 5'd14; bus.c0_wdata = 32'h55;
        tick();
        bus.c0_we = 0;
        bus.eret = 1;
        tick();
        bus.eret = 0;
        chk_out("pri.return", 1'b1, 32'h8C);
        rd("pri.status", 5'd12, 32'h0F);
        tick();

        // interrupt edge -> IP, then ENTER with EPC=next_pc
        bus.intr = 1; bus.next_pc = 32'hA8;
        tick();
        chk_out("irq.pend", 1'b0, 32'h0);
        rd("irq.ip", 5'd13, 32'h108);
        tick();
        chk_out("irq.enter", 1'b1, 32'h08);
        rd("irq.epc", 5'd14, 32'hA8);
        rd("irq.cause", 5'd13, 32'h000);
        tick();
        bus.eret = 1;
        tick();
        bus.eret = 0;
        chk_out("irq.return", 1'b1, 32'hA8);
        tick(); tick(); tick();
        chk_out("irq.held", 1'b0, 32'h0);
        rd("irq.noip", 5'd13, 32'h000);
        bus.intr = 0;
        tick();

        // events inside HANDLER
        bus.exc_ovf = 1; bus.exc_pc = 32'hB0;
        tick();
        bus.exc_ovf = 0;
        tick();
        bus.exc_sys = 1;
        tick();
        bus.exc_sys = 0;
        chk_out("hnd.sys", 1'b0, 32'h0);
        rd("hnd.sys.epc", 5'd14, 32'hB0);
        bus.intr = 1; bus.next_pc = 32'hC0;
        tick();
        rd("hnd.ip", 5'd13, 32'h10C);
        bus.eret = 1;
        tick();
        bus.eret = 0;
        chk_out("hnd.return", 1'b1, 32'hB0);
        tick();
        chk_out("hnd.idle", 1'b0, 32'h0);
        tick();
        chk_out("hnd.reenter", 1'b1, 32'h08);
        rd("hnd.epc", 5'd14, 32'hC0);
        tick();
        bus.eret = 1;
        tick();
        bus.eret = 0;
        tick();
        bus.intr = 0;

        // partial mask drops ovf; mtc0 EPC with eret
        wr(5'd12, 32'h01);
        bus.exc_ovf = 1; bus.exc_pc = 32'hE0;
        tick();
        bus.exc_ovf = 0;
        chk_out("mask.ovf", 1'b0, 32'h0);
        rd("mask.epc", 5'd14, 32'hC0);
        rd("mask.status", 5'd12, 32'h01);
        bus.intr = 1; bus.next_pc = 32'hD4;
        tick(); tick();
        chk_out("mask.irq", 1'b1, 32'h08);
        rd("mask.irq.status", 5'd12, 32'h11);
        tick();
        bus.c0_we = 1; bus.c0_addr = 5'd14; bus.c0_wdata = 32'h90; bus.eret = 1;
        tick();
        bus.c0_we = 0; bus.eret = 0;
        chk_out("epcw.return", 1'b1, 32'h90);
        tick();
        bus.intr = 0;

        // masked interrupt stays pending; Cause is read-only; unmapped reads 0
        wr(5'd12, 32'h00);
        bus.intr = 1;
        tick(); tick(); tick();
        chk_out("pend.masked", 1'b0, 32'h0);
        wr(5'd13, 32'hFFFF_FFFF);
        rd("pend.cause", 5'd13, 32'h100);
        rd("unmapped", 5'd5, 32'h0);
        bus.next_pc = 32'hF0;
        wr(5'd12, 32'h01);
        chk_out("pend.wait", 1'b0, 32'h0);
        tick();
        chk_out("pend.enter", 1'b1, 32'h08);
        rd("pend.epc", 5'd14, 32'hF0);
        tick();

        // reset in HANDLER aborts sequence
        #2;
        rst = 1;
        #1;
        chk_out("rsth", 1'b0, 32'h0);
        rd("rsth.status", 5'd12, 32'h0);
        rd("rsth.cause", 5'd13, 32'h0);
        rd("rsth.epc", 5'd14, 32'h0);
        tick();
        rst = 0;
        bus.eret = 1;
        tick();
        bus.eret = 0;
        chk_out("rsth.eret", 1'b0, 32'h0);
        tick();
        chk_out("rsth.idle", 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/exc_intr_ctrl.md
EXC_INTR_CTRL -- requirements
Module: exc_intr_ctrl

Interface
REQ-001 The block SHALL have these ports (name direction width meaning):
REQ-002 clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 intr  in  1  external interrupt request, level.
REQ-005 exc_sys, exc_uni, exc_ovf  in  1 each  syscall, unimplemented-instruction and overflow flags for the instruction at exc_pc.
REQ-006 exc_pc  in  32  PC of the faulting instruction.
REQ-007 next_pc  in  32  PC of the oldest not-yet-completed instruction; this is the interrupt return point.
REQ-008 eret  in  1  eret decoded.
REQ-009 c0_we  in  1  mtc0 write strobe.
REQ-010 c0_addr  in  5  CP0 register select.
REQ-011 c0_wdata  in  32  mtc0 data.
REQ-012 c0_rdata  out  32  mfc0 data, combinational.
REQ-013 redirect  out  1  PC override strobe.
REQ-014 redirect_pc  out  32  PC override target.
REQ-015 flush  out  1  kill all in-flight instructions.

Function
REQ-016 CP0 registers SHALL be: Status (addr 12) = bits[4:0], where [3:0] are per-cause enables IM and [4] is EXL; Cause (addr 13) = ExcCode in [3:2], interrupt pending IP in [8]; EPC (addr 14) = 32 bits.
REQ-017 ExcCode encoding SHALL be: 0 interrupt, 1 syscall, 2 unimplemented, 3 overflow; IM[n] SHALL enable ExcCode n.
REQ-018 c0_rdata SHALL return zero-extended Status, Cause or EPC for addr 12/13/14, and 0 for any other addr.
REQ-019 mtc0 SHALL write Status[4:0] (addr 12) or EPC (addr 14) at the clock edge; writes to Cause or other addresses SHALL be ignored.
REQ-020 IP SHALL set on an intr 0->1 edge, detected by a registered previous value, and clear only when the interrupt is accepted.
REQ-021 FSM states SHALL be IDLE, ENTER, HANDLER, RETURN.
REQ-022 In IDLE with EXL=0, an event is accepted if its IM bit is 1; the fixed priority SHALL be ovf > uni > sys > interrupt (IP=1).
REQ-023 On acceptance the block SHALL, at that edge, load ExcCode and set EXL; EPC SHALL be loaded with exc_pc for exceptions and with next_pc for interrupts; state SHALL go to ENTER.
REQ-024 A masked exception, or any exception while EXL=1, SHALL be dropped with no state change; a masked interrupt SHALL stay pending in IP.
REQ-025 ENTER SHALL last exactly one cycle with redirect=1, flush=1 and redirect_pc=0x00000008, then go to HANDLER.
REQ-026 HANDLER SHALL wait for eret; at that edge EXL SHALL clear and state SHALL go to RETURN.
REQ-027 RETURN SHALL last exactly one cycle with redirect=1, flush=1 and redirect_pc=EPC, then go to IDLE.
REQ-028 An mtc0 to EPC in the same cycle as eret SHALL take effect, so RETURN uses the new value.
REQ-029 eret in IDLE SHALL be ignored.
REQ-030 All event, eret and c0_we inputs SHALL be ignored during ENTER and RETURN.
REQ-031 An interrupt arriving during HANDLER SHALL be latched in IP and taken in IDLE after RETURN, if still enabled.
REQ-032 Latency from event sample edge to redirect SHALL be 1 cycle; outside ENTER and RETURN, redirect, flush and redirect_pc SHALL all be 0.

Reset
REQ-033 rst=1 SHALL immediately force: Status=0, Cause=0, EPC=0, the previous-intr register=0, state=IDLE, redirect=0, flush=0, redirect_pc=0.
REQ-034 Reset asserted mid-ENTER or mid-HANDLER SHALL abort the sequence with no redirect emitted.
REQ-035 After reset all sources SHALL be masked until software writes Status.

Verification
REQ-036 mtc0 Status=0x0F; exc_ovf=1, exc_pc=0x84 -> next cycle redirect=1, redirect_pc=0x08, flush=1; Cause=0x0C, EPC=0x84, Status=0x1F.
REQ-037 Status=0x0F; exc_sys and exc_uni asserted together, exc_pc=0x8C -> ExcCode=2; after eret, RETURN redirect_pc=0x8C and Status=0x0F.
REQ-038 Status=0x0F; intr pulse 0->1, next_pc=0xA8 -> IP=1, then ENTER with EPC=0xA8 and Cause=0x000; intr held high afterwards -> no second interrupt.
REQ-039 In HANDLER: exc_sys=1 -> no effect; intr edge -> IP=1; eret -> RETURN, then ENTER again for the interrupt.
REQ-040 Status=0x01; exc_ovf=1 -> dropped, redirect stays 0; mtc0 EPC=0x90 with eret in HANDLER -> redirect_pc=0x90.
REQ-041 rst pulsed during HANDLER -> all registers 0, state IDLE; a subsequent eret produces no redirect.
